// File: rtl/rank_order_encoder.sv
// Rank-order encoder: histograms one image, counting-sorts pixel indices by
// intensity and streams the ranked indices out over a 4-phase AER link.
module rank_order_encoder #(
  parameter int                  IMAGE_SIZE     = 256,
  parameter int                  PIXEL_BITS     = 8,
  parameter int                  AER_BITS       = 10,
  parameter int                  N_RST_EVENTS   = 2,
  parameter logic [AER_BITS-1:0] RST_EVENT_WORD = 10'h1FF
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          START,
  input  logic                          DESCENDING,
  input  logic [PIXEL_BITS-1:0]         THRESHOLD,
  input  logic [$clog2(IMAGE_SIZE):0]   MAX_EVENTS,
  input  logic                          ABORT,
  input  logic                          PIX_VALID,
  input  logic [PIXEL_BITS-1:0]         PIX_DATA,
  output logic                          PIX_READY,
  output logic                          AER_REQ,
  output logic [AER_BITS-1:0]           AER_ADDR,
  input  logic                          AER_ACK,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [$clog2(IMAGE_SIZE):0]   EVENT_COUNT
);
  localparam int IW    = $clog2(IMAGE_SIZE);
  localparam int CW    = IW + 1;
  localparam int NB    = 1 << PIXEL_BITS;
  localparam int NR_W  = $clog2(N_RST_EVENTS + 1);
  localparam int M1    = (IW > PIXEL_BITS) ? IW : PIXEL_BITS;
  localparam int CNT_W = ((M1 > NR_W) ? M1 : NR_W) + 1;

  typedef enum logic [2:0] {S_IDLE, S_RST_SEQ, S_LOAD, S_PREFIX, S_SCATTER, S_EMIT, S_FINISH} state_t;
  typedef enum logic [1:0] {PH_ADDR, PH_RAISE, PH_WAIT, PH_REL} phase_t;

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [CW-1:0]         run_q, run_d;
  logic [CW-1:0]         elig_q, elig_d;
  logic [CW-1:0]         event_count_q, event_count_d;
  logic [AER_BITS-1:0]   aer_addr_q, aer_addr_d;
  logic                  aer_req_q, aer_req_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  busy_q, busy_d, done_q, done_d, pix_ready_q, pix_ready_d;
  logic                  desc_q, desc_d;
  logic [PIXEL_BITS-1:0] thr_q, thr_d;
  logic [CW-1:0]         max_q, max_d;

  logic [PIXEL_BITS-1:0] pix_mem [IMAGE_SIZE];
  logic [IW-1:0]         sorted_mem [IMAGE_SIZE];
  logic [CW-1:0]         bin_q [NB];

  logic                  bin_clr, bin_we, pix_we, sort_we;
  logic [PIXEL_BITS-1:0] bin_wa, pix_v, pb;
  logic [CW-1:0]         bin_wd, k_c;
  logic [IW-1:0]         sort_wa;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    idx_d         = idx_q;
    run_d         = run_q;
    elig_d        = elig_q;
    event_count_d = event_count_q;
    aer_addr_d    = aer_addr_q;
    aer_req_d     = aer_req_q;
    abort_pend_d  = abort_pend_q;
    desc_d        = desc_q;
    thr_d         = thr_q;
    max_d         = max_q;
    bin_clr       = 1'b0;
    bin_we        = 1'b0;
    bin_wa        = '0;
    bin_wd        = '0;
    pix_we        = 1'b0;
    sort_we       = 1'b0;
    sort_wa       = '0;
    pix_v         = pix_mem[idx_q[IW-1:0]];
    // Descending mode walks bins from the top value down.
    pb            = desc_q ? ~idx_q[PIXEL_BITS-1:0] : idx_q[PIXEL_BITS-1:0];
    k_c           = (max_q == '0 || elig_q < max_q) ? elig_q : max_q;

    unique case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (START && !ABORT) begin
          desc_d        = DESCENDING;
          thr_d         = THRESHOLD;
          max_d         = MAX_EVENTS;
          bin_clr       = 1'b1;
          event_count_d = '0;
          elig_d        = '0;
          idx_d         = '0;
          phase_d       = PH_ADDR;
          state_d       = (N_RST_EVENTS == 0) ? S_LOAD : S_RST_SEQ;
        end
      end
      S_RST_SEQ, S_EMIT: begin
        unique case (phase_q)
          PH_ADDR: begin
            if (state_q == S_RST_SEQ) begin
              if (idx_q == CNT_W'(N_RST_EVENTS)) begin
                state_d = S_LOAD;
                idx_d   = '0;
              end else begin
                aer_addr_d = RST_EVENT_WORD;
                phase_d    = PH_RAISE;
              end
            end else if (event_count_q == k_c) begin
              state_d = S_FINISH;
            end else begin
              aer_addr_d = AER_BITS'(sorted_mem[event_count_q[IW-1:0]]);
              phase_d    = PH_RAISE;
            end
          end
          PH_RAISE: begin
            aer_req_d = 1'b1;
            phase_d   = PH_WAIT;
          end
          PH_WAIT: begin
            if (AER_ACK) begin
              aer_req_d = 1'b0;
              phase_d   = PH_REL;
              if (state_q == S_EMIT) event_count_d = event_count_q + 1'b1;
              else                   idx_d         = idx_q + 1'b1;
            end
          end
          PH_REL: begin
            if (!AER_ACK) begin
              phase_d = PH_ADDR;
              if (abort_pend_q) begin
                state_d      = S_IDLE;
                abort_pend_d = 1'b0;
              end
            end
          end
          default: phase_d = PH_ADDR;
        endcase
      end
      S_LOAD: begin
        if (PIX_VALID && pix_ready_q) begin
          pix_we = 1'b1;
          bin_we = 1'b1;
          bin_wa = PIX_DATA;
          bin_wd = bin_q[PIX_DATA] + 1'b1;
          if (desc_q ? (PIX_DATA >= thr_q) : (PIX_DATA <= thr_q)) elig_d = elig_q + 1'b1;
          if (idx_q == CNT_W'(IMAGE_SIZE - 1)) begin
            state_d = S_PREFIX;
            idx_d   = '0;
            run_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PREFIX: begin
        bin_we = 1'b1;
        bin_wa = pb;
        bin_wd = run_q;
        run_d  = run_q + bin_q[pb];
        if (idx_q == CNT_W'(NB - 1)) begin
          state_d = S_SCATTER;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_SCATTER: begin
        bin_we  = 1'b1;
        bin_wa  = pix_v;
        bin_wd  = bin_q[pix_v] + 1'b1;
        sort_we = 1'b1;
        sort_wa = bin_q[pix_v][IW-1:0];
        if (idx_q == CNT_W'(IMAGE_SIZE - 1)) begin
          state_d = S_EMIT;
          phase_d = PH_ADDR;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // An abort with no request outstanding is immediate; otherwise it waits
    // for the running handshake to close.
    if (ABORT && !aer_req_q && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      phase_d      = PH_ADDR;
      aer_req_d    = 1'b0;
      abort_pend_d = 1'b0;
      bin_we       = 1'b0;
      pix_we       = 1'b0;
      sort_we      = 1'b0;
    end else if (ABORT && aer_req_q) begin
      abort_pend_d = 1'b1;
    end

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH);
    pix_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= S_IDLE;
      phase_q       <= PH_ADDR;
      idx_q         <= '0;
      run_q         <= '0;
      elig_q        <= '0;
      event_count_q <= '0;
      aer_addr_q    <= '0;
      aer_req_q     <= 1'b0;
      abort_pend_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pix_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      run_q         <= run_d;
      elig_q        <= elig_d;
      event_count_q <= event_count_d;
      aer_addr_q    <= aer_addr_d;
      aer_req_q     <= aer_req_d;
      abort_pend_q  <= abort_pend_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pix_ready_q   <= pix_ready_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NB; i++) bin_q[i] <= '0;
    end else if (bin_clr) begin
      for (int i = 0; i < NB; i++) bin_q[i] <= '0;
    end else if (bin_we) begin
      bin_q[bin_wa] <= bin_wd;
    end
  end

  always_ff @(posedge CLK) begin
    desc_q <= desc_d;
    thr_q  <= thr_d;
    max_q  <= max_d;
    if (pix_we)  pix_mem[idx_q[IW-1:0]] <= PIX_DATA;
    if (sort_we) sorted_mem[sort_wa]    <= idx_q[IW-1:0];
  end

  assign PIX_READY   = pix_ready_q;
  assign AER_REQ     = aer_req_q;
  assign AER_ADDR    = aer_addr_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign EVENT_COUNT = event_count_q;
endmodule

// File: tb/tb_rank_order_encoder.sv
// Scoreboard bench for rank_order_encoder: expected AER words are queued at
// stimulus time and checked by the AER responder as requests appear.
module tb_rank_order_encoder;
  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       START = 1'b0;
  logic       DESCENDING = 1'b0;
  logic [2:0] THRESHOLD = '0;
  logic [3:0] MAX_EVENTS = '0;
  logic       ABORT = 1'b0;
  logic       PIX_VALID = 1'b0;
  logic [2:0] PIX_DATA = '0;
  logic       PIX_READY;
  logic       AER_REQ;
  logic [9:0] AER_ADDR;
  logic       AER_ACK;
  logic       BUSY;
  logic       DONE;
  logic [3:0] EVENT_COUNT;

  int total = 0, bad = 0, done_cnt = 0, req_seen = 0, unstable = 0, ack_max = 0, tmo = 0;
  logic [9:0] exp_q[$];

  always #5 CLK = ~CLK;

  rank_order_encoder #(.IMAGE_SIZE(8), .PIXEL_BITS(3), .AER_BITS(10), .N_RST_EVENTS(2),
                       .RST_EVENT_WORD(10'h1FF)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .DESCENDING(DESCENDING), .THRESHOLD(THRESHOLD),
    .MAX_EVENTS(MAX_EVENTS), .ABORT(ABORT), .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA),
    .PIX_READY(PIX_READY), .AER_REQ(AER_REQ), .AER_ADDR(AER_ADDR), .AER_ACK(AER_ACK),
    .BUSY(BUSY), .DONE(DONE), .EVENT_COUNT(EVENT_COUNT));

  // AER receiver: pops the scoreboard on every new request.
  initial begin : responder
    logic [9:0] held, last, e;
    int n;
    AER_ACK = 1'b0;
    last = '0;
    forever begin
      @(posedge CLK); #1;
      if (AER_REQ && !AER_ACK) begin
        req_seen++;
        held = AER_ADDR;
        if (AER_ADDR !== last) unstable++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL aer_extra got=%h required=none", AER_ADDR);
        end else begin
          e = exp_q.pop_front();
          if (AER_ADDR !== e) begin bad++; $display("FAIL aer_addr got=%h required=%h", AER_ADDR, e); end
        end
        repeat ($urandom_range(0, ack_max)) begin
          @(posedge CLK); #1;
          if (AER_REQ && AER_ADDR !== held) unstable++;
        end
        AER_ACK = 1'b1;
        n = 0;
        while (AER_REQ && n < 100) begin
          @(posedge CLK); #1; n++;
          if (AER_REQ && AER_ADDR !== held) unstable++;
        end
        AER_ACK = 1'b0;
      end
      last = AER_ADDR;
    end
  end

  initial forever begin
    @(posedge CLK); #1;
    if (DONE) done_cnt++;
  end

  function automatic logic [23:0] img8(input int p0, p1, p2, p3, p4, p5, p6, p7);
    return {p7[2:0], p6[2:0], p5[2:0], p4[2:0], p3[2:0], p2[2:0], p1[2:0], p0[2:0]};
  endfunction

  // Queues the two reset words then n pixel indices, first index in the top nibble.
  task automatic push_events(input logic [31:0] list, input int n);
    exp_q.push_back(10'h1FF);
    exp_q.push_back(10'h1FF);
    for (int i = 0; i < n; i++) exp_q.push_back(10'(list[4*(n-1-i) +: 4]));
  endtask

  task automatic drive_encode(input bit desc, input logic [2:0] thr, input logic [3:0] maxev,
                              input logic [23:0] img, input int gap_max);
    int c;
    @(negedge CLK);
    DESCENDING = desc; THRESHOLD = thr; MAX_EVENTS = maxev; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; DESCENDING = ~desc; THRESHOLD = ~thr; MAX_EVENTS = 4'd1;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge CLK);
      PIX_VALID = 1'b1; PIX_DATA = img[3*i +: 3];
      c = 0;
      while (!PIX_READY && c < 500) begin @(negedge CLK); c++; end
      if (c >= 500) begin tmo++; PIX_VALID = 1'b0; return; end
      @(negedge CLK);
      PIX_VALID = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while (BUSY && c < 3000) begin @(negedge CLK); c++; end
    if (c >= 3000) tmo++;
  endtask

  task automatic test_reset();
    int c;
    total++;
    if ({AER_REQ, BUSY, PIX_READY, DONE, EVENT_COUNT} !== 8'h00) begin
      bad++; $display("FAIL reset_held got=%b required=0", {AER_REQ, BUSY, PIX_READY, DONE, EVENT_COUNT});
    end
    @(negedge CLK); RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    total++;
    if ({AER_REQ, BUSY, PIX_READY, DONE, EVENT_COUNT} !== 8'h00 || AER_ADDR !== 10'h0) begin
      bad++; $display("FAIL reset_idle got=%b addr=%h required=0", {AER_REQ, BUSY, PIX_READY, DONE, EVENT_COUNT}, AER_ADDR);
    end
    // Reset while a request is outstanding must drop REQ at once.
    ack_max = 4;
    push_events(32'h0, 0);
    @(negedge CLK); DESCENDING = 1'b1; THRESHOLD = '0; MAX_EVENTS = '0; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    c = 0;
    while (!AER_REQ && c < 100) begin @(negedge CLK); c++; end
    #2 RSTN = 1'b0; #1;
    total++;
    if (c >= 100 || {AER_REQ, BUSY, PIX_READY, DONE, EVENT_COUNT} !== 8'h00) begin
      bad++; $display("FAIL reset_rstseq got=%b wait=%0d required=0", {AER_REQ, BUSY, PIX_READY, DONE, EVENT_COUNT}, c);
    end
    @(negedge CLK); @(negedge CLK); RSTN = 1'b1;
    repeat (10) @(negedge CLK);
    exp_q.delete();
    // Reset in EMIT with events already counted.
    push_events(32'h13460752, 8);
    drive_encode(1'b1, 3'd0, 4'd0, img8(3, 7, 0, 7, 5, 1, 5, 2), 0);
    c = 0;
    while (EVENT_COUNT != 4'd3 && c < 1000) begin @(negedge CLK); c++; end
    #2 RSTN = 1'b0; #1;
    total++;
    if (c >= 1000 || {AER_REQ, BUSY, PIX_READY, DONE, EVENT_COUNT} !== 8'h00) begin
      bad++; $display("FAIL reset_emit got=%b wait=%0d required=0", {AER_REQ, BUSY, PIX_READY, DONE, EVENT_COUNT}, c);
    end
    @(negedge CLK); @(negedge CLK); RSTN = 1'b1;
    repeat (10) @(negedge CLK);
    exp_q.delete();
    unstable = 0;
  endtask

  task automatic test_descending();
    int d0 = done_cnt;
    ack_max = 2;
    push_events(32'h13460752, 8);
    drive_encode(1'b1, 3'd0, 4'd0, img8(3, 7, 0, 7, 5, 1, 5, 2), 0);
    wait_idle();
    total++; if (EVENT_COUNT !== 4'd8) begin bad++; $display("FAIL desc_count got=%0d required=8", EVENT_COUNT); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL desc_done got=%0d required=1", done_cnt - d0); end
    total++; if (exp_q.size() !== 0 || tmo !== 0) begin bad++; $display("FAIL desc_drain left=%0d tmo=%0d required=0", exp_q.size(), tmo); end
    exp_q.delete();
  endtask

  task automatic test_ascending();
    int d0 = done_cnt;
    push_events(32'h25704613, 8);
    drive_encode(1'b0, 3'd7, 4'd0, img8(3, 7, 0, 7, 5, 1, 5, 2), 1);
    wait_idle();
    total++; if (EVENT_COUNT !== 4'd8) begin bad++; $display("FAIL asc_count got=%0d required=8", EVENT_COUNT); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL asc_done got=%0d required=1", done_cnt - d0); end
    total++; if (exp_q.size() !== 0 || tmo !== 0) begin bad++; $display("FAIL asc_drain left=%0d tmo=%0d required=0", exp_q.size(), tmo); end
    exp_q.delete();
  endtask

  task automatic test_threshold();
    push_events(32'h1346, 4);
    drive_encode(1'b1, 3'd5, 4'd0, img8(3, 7, 0, 7, 5, 1, 5, 2), 0);
    wait_idle();
    total++; if (EVENT_COUNT !== 4'd4) begin bad++; $display("FAIL thr_count got=%0d required=4", EVENT_COUNT); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL thr_drain left=%0d required=0", exp_q.size()); end
    exp_q.delete();
    push_events(32'h134, 3);
    drive_encode(1'b1, 3'd5, 4'd3, img8(3, 7, 0, 7, 5, 1, 5, 2), 0);
    wait_idle();
    total++; if (EVENT_COUNT !== 4'd3) begin bad++; $display("FAIL cap_count got=%0d required=3", EVENT_COUNT); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL cap_drain left=%0d required=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_same_value_gaps();
    int d0 = done_cnt;
    ack_max = 5;
    unstable = 0;
    push_events(32'h01234567, 8);
    drive_encode(1'b1, 3'd0, 4'd0, img8(7, 7, 7, 7, 7, 7, 7, 7), 3);
    wait_idle();
    total++; if (EVENT_COUNT !== 4'd8) begin bad++; $display("FAIL same_count got=%0d required=8", EVENT_COUNT); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL same_drain left=%0d required=0", exp_q.size()); end
    exp_q.delete();
    // No eligible pixel: only the reset words, yet still a DONE.
    push_events(32'h0, 0);
    drive_encode(1'b0, 3'd6, 4'd0, img8(7, 7, 7, 7, 7, 7, 7, 7), 2);
    wait_idle();
    total++; if (EVENT_COUNT !== 4'd0) begin bad++; $display("FAIL k0_count got=%0d required=0", EVENT_COUNT); end
    total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL k0_done got=%0d required=2", done_cnt - d0); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL addr_stable got=%0d required=0", unstable); end
    exp_q.delete();
  endtask

  task automatic test_abort();
    int c, d0, r0;
    ack_max = 3;
    @(negedge CLK); START = 1'b1; ABORT = 1'b1;
    @(negedge CLK); START = 1'b0; ABORT = 1'b0;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL start_abort_busy got=%b required=0", BUSY); end
    d0 = done_cnt;
    push_events(32'h13460752, 8);
    drive_encode(1'b1, 3'd0, 4'd0, img8(3, 7, 0, 7, 5, 1, 5, 2), 0);
    c = 0;
    while (!(AER_REQ && EVENT_COUNT == 4'd2) && c < 1000) begin @(negedge CLK); c++; end
    ABORT = 1'b1;
    @(negedge CLK); ABORT = 1'b0;
    wait_idle();
    r0 = req_seen;
    repeat (20) @(negedge CLK);
    total++; if (c >= 1000 || tmo !== 0) begin bad++; $display("FAIL abort_reach wait=%0d tmo=%0d required=ok", c, tmo); end
    total++; if (BUSY !== 1'b0 || AER_REQ !== 1'b0) begin bad++; $display("FAIL abort_idle busy=%b req=%b required=0", BUSY, AER_REQ); end
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL abort_done got=%0d required=%0d", done_cnt, d0); end
    total++; if (req_seen !== r0 || exp_q.size() !== 5) begin bad++; $display("FAIL abort_stop reqs=%0d/%0d left=%0d required=5", req_seen, r0, exp_q.size()); end
    total++; if (EVENT_COUNT !== 4'd3) begin bad++; $display("FAIL abort_count got=%0d required=3", EVENT_COUNT); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back(input int runs);
    logic [23:0] img;
    logic [2:0]  thr, v;
    logic [3:0]  maxev;
    bit          desc;
    int          lim, k, d0;
    ack_max = 2;
    for (int r = 0; r < runs; r++) begin
      img = 24'($urandom); desc = 1'($urandom); thr = 3'($urandom);
      maxev = 4'($urandom_range(0, 8));
      lim = (maxev == 0) ? 8 : int'(maxev);
      k = 0;
      exp_q.push_back(10'h1FF); exp_q.push_back(10'h1FF);
      for (int rr = 0; rr < 8; rr++) begin
        v = desc ? 3'(7 - rr) : 3'(rr);
        for (int i = 0; i < 8; i++)
          if (img[3*i +: 3] == v && (desc ? v >= thr : v <= thr) && k < lim) begin
            exp_q.push_back(10'(i)); k++;
          end
      end
      d0 = done_cnt;
      drive_encode(desc, thr, maxev, img, 2);
      wait_idle();
      total++; if (EVENT_COUNT !== 4'(k)) begin bad++; $display("FAIL rand%0d_count got=%0d required=%0d", r, EVENT_COUNT, k); end
      total++; if (done_cnt - d0 !== 1 || exp_q.size() !== 0) begin bad++; $display("FAIL rand%0d_end done=%0d left=%0d required=1/0", r, done_cnt - d0, exp_q.size()); end
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    test_reset();
    test_descending();
    test_ascending();
    test_threshold();
    test_same_value_gaps();
    test_abort();
    test_back_to_back(6);
    total++; if (tmo !== 0) begin bad++; $display("FAIL timeouts got=%0d required=0", tmo); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rank_order_encoder.md
RANK_ORDER_ENCODER -- requirements
Module: rank_order_encoder

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 256: number of pixels per image.
REQ-002 SHALL have parameter PIXEL_BITS, default 8: pixel intensity width; histogram has 2^PIXEL_BITS bins.
REQ-003 SHALL have parameter AER_BITS, default 10: AER address width; must be at least clog2(IMAGE_SIZE).
REQ-004 SHALL have parameter N_RST_EVENTS, default 2: number of AER reset events sent before image events; 0 disables them.
REQ-005 SHALL have parameter RST_EVENT_WORD, default 10'h1FF: AER address used for each reset event.
REQ-006 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port RSTN, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port START, input, 1: begin one encode; sampled only in IDLE.
REQ-009 SHALL have port DESCENDING, input, 1: 1 = brightest first, 0 = darkest first; latched at START.
REQ-010 SHALL have port THRESHOLD, input, PIXEL_BITS: eligibility bound; latched at START.
REQ-011 SHALL have port MAX_EVENTS, input, clog2(IMAGE_SIZE)+1: cap on emitted image events, 0 = no cap; latched at START.
REQ-012 SHALL have port ABORT, input, 1: cancel the current encode.
REQ-013 SHALL have ports PIX_VALID (input, 1), PIX_DATA (input, PIXEL_BITS) and PIX_READY (output, 1): pixel stream, raster order, index 0 first.
REQ-014 SHALL have ports AER_REQ (output, 1), AER_ADDR (output, AER_BITS) and AER_ACK (input, 1): 4-phase AER link.
REQ-015 SHALL have port BUSY, output, 1: high in every state except IDLE.
REQ-016 SHALL have port DONE, output, 1: one-cycle pulse on normal completion.
REQ-017 SHALL have port EVENT_COUNT, output, clog2(IMAGE_SIZE)+1: number of image events emitted by the last encode.

Function
REQ-018 SHALL implement the FSM IDLE -> RST_SEQ -> LOAD -> PREFIX -> SCATTER -> EMIT -> FINISH -> IDLE; RST_SEQ is skipped when N_RST_EVENTS=0.
REQ-019 IDLE: when START=1 and ABORT=0, SHALL latch the mode inputs, clear all histogram bins and EVENT_COUNT, and leave IDLE the next cycle; START outside IDLE SHALL be ignored.
REQ-020 RST_SEQ: SHALL send N_RST_EVENTS AER events with AER_ADDR=RST_EVENT_WORD.
REQ-021 LOAD: PIX_READY SHALL be high only in LOAD; each PIX_VALID&&PIX_READY beat SHALL store the pixel, increment its bin, and increment the eligible count when the pixel is eligible.
REQ-022 LOAD SHALL end after exactly IMAGE_SIZE beats; gaps in PIX_VALID SHALL stall LOAD without error.
REQ-023 Eligibility: a pixel SHALL be eligible when value>=THRESHOLD in descending mode, or value<=THRESHOLD in ascending mode.
REQ-024 PREFIX: SHALL take one bin per cycle, 2^PIXEL_BITS cycles, in priority order (highest value first when descending), converting counts to exclusive start offsets.
REQ-025 SCATTER: SHALL take one pixel per cycle, index 0 to IMAGE_SIZE-1, writing sorted[start[v]]=index and then incrementing start[v]; ties SHALL therefore emit in ascending pixel index (stable).
REQ-026 Bin counters SHALL be clog2(IMAGE_SIZE)+1 bits wide, so that all IMAGE_SIZE pixels in one bin does not overflow.
REQ-027 EMIT: SHALL send K = min(eligible count, MAX_EVENTS), or K = eligible count when MAX_EVENTS=0, from sorted[0..K-1]; AER_ADDR SHALL be the pixel index zero-extended to AER_BITS.
REQ-028 EMIT with K=0 SHALL go straight to FINISH.
REQ-029 AER handshake: SHALL set AER_ADDR, then raise AER_REQ one or more cycles later; AER_ADDR SHALL be held stable while AER_REQ=1.
REQ-030 AER handshake, continued: on AER_ACK=1 SHALL drop AER_REQ; the next event SHALL start only after AER_ACK=0 is seen.
REQ-031 EVENT_COUNT SHALL increment when each image event's ACK is seen and SHALL hold after FINISH.
REQ-032 FINISH: SHALL assert DONE for exactly one cycle, then go to IDLE.
REQ-033 ABORT when AER_REQ=0 (outside IDLE) SHALL return the FSM to IDLE on the next cycle.
REQ-034 ABORT when AER_REQ=1 SHALL first complete the current handshake (ACK high, REQ drop, ACK low) and then go to IDLE.
REQ-035 An aborted encode SHALL NOT assert DONE.
REQ-036 START and ABORT both high in IDLE: ABORT SHALL win and the FSM SHALL stay in IDLE.
REQ-037 Latency with no stalls: RST_SEQ, then IMAGE_SIZE + 2^PIXEL_BITS + IMAGE_SIZE cycles, then EMIT, then 1 cycle of FINISH.

Reset
REQ-038 RSTN=0 SHALL, asynchronously, set: FSM=IDLE, AER_REQ=0, AER_ADDR=0, PIX_READY=0, BUSY=0, DONE=0, EVENT_COUNT=0, all bins=0.
REQ-039 RSTN=0 mid-handshake SHALL drop AER_REQ immediately; this is the one allowed protocol violation.
REQ-040 Pixel and sorted storage need no reset.

Verification (IMAGE_SIZE=8, PIXEL_BITS=3, N_RST_EVENTS=2, RST_EVENT_WORD=0x1FF)
REQ-041 Reset: RSTN low at any state -> AER_REQ=0, BUSY=0, PIX_READY=0, DONE=0, EVENT_COUNT=0.
REQ-042 Descending, THRESHOLD=0, MAX_EVENTS=0, image [3,7,0,7,5,1,5,2] -> AER 0x1FF,0x1FF,1,3,4,6,0,7,5,2; EVENT_COUNT=8; one DONE pulse.
REQ-043 Ascending on the same image -> AER 0x1FF,0x1FF,2,5,7,0,4,6,1,3; EVENT_COUNT=8.
REQ-044 Descending, THRESHOLD=5 -> image events 1,3,4,6 with EVENT_COUNT=4; adding MAX_EVENTS=3 -> 1,3,4 with EVENT_COUNT=3.
REQ-045 All pixels=7 with random PIX_VALID gaps and 0-5 cycle ACK delays -> events 0..7 in order, no bin overflow, AER_ADDR stable while REQ high.
REQ-046 ABORT while AER_REQ=1 in EMIT -> handshake completes, BUSY=0, no DONE, no further REQ; a following START runs a full correct encode.
